// File: rtl/odev1_pkg.sv
// Shared types and constants for the odev1 stimulus/capture sequencer.
// Eight vectors are swept, so the index is three bits wide.
package odev1_pkg;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/odev1_hold_cnt.sv
// Hold-window counter: counts 0..HOLD_CYCLES-1 while enabled and wraps.
// The last flag marks the final cycle of each window.
module odev1_hold_cnt #(
    parameter int HOLD_CYCLES = 5,
    parameter int HOLD_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam logic [HOLD_W-1:0] LAST_VAL = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] r_cnt;
    logic              w_last;

    assign w_last = (r_cnt == LAST_VAL);
    assign o_last = w_last;

    // Clear has priority so a run always starts from a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/odev1_vec_seq.sv
// Sweeps {a,b,c} through 000..111, holding each vector HOLD_CYCLES cycles,
// and captures f/q at the end of each window into two 8-bit truth tables.
module odev1_vec_seq
    import odev1_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int HOLD_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               f,
    input  logic               q,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic [IDX_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] f_table,
    output logic [NUM_VEC-1:0] q_table
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [IDX_W-1:0]   r_vec_idx;
    logic [NUM_VEC-1:0] r_f_table;
    logic [NUM_VEC-1:0] r_q_table;
    logic               w_last;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_final;

    odev1_hold_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_last (w_last)
    );

    assign w_final = w_last && (r_vec_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b1;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = DRIVE;
                end
            end
            DRIVE: begin
                w_cnt_clr = 1'b0;
                w_cnt_en  = 1'b1;
                if (w_final) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The index drops to 0 on the final sample so {a,b,c} reads 000 in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_idx <= '0;
            r_f_table <= '0;
            r_q_table <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec_idx <= '0;
                        r_f_table <= '0;
                        r_q_table <= '0;
                    end
                end
                DRIVE: begin
                    if (w_last) begin
                        r_f_table[r_vec_idx] <= f;
                        r_q_table[r_vec_idx] <= q;
                        r_vec_idx            <= w_final ? '0 : r_vec_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {a, b, c} = r_vec_idx;
    assign vec_idx   = r_vec_idx;
    assign busy      = (r_state == DRIVE);
    assign done      = (r_state == DONE);
    assign f_table   = r_f_table;
    assign q_table   = r_q_table;

endmodule

// File: tb/tb_odev1_vec_seq.sv
// Scoreboard bench for odev1_vec_seq: one instance at H=5, one at H=1,
// each fed by a stub function of its own {a,b,c}.
module tb_odev1_vec_seq;

    typedef struct packed {
        logic [7:0] f;
        logic [7:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode5 = 0;
    int mode1 = 0;

    logic       s5 = 1'b0, f5, q5, a5, b5, c5, busy5, done5;
    logic [2:0] idx5;
    logic [7:0] ft5, qt5;
    logic       s1 = 1'b0, f1, q1, a1, b1, c1, busy1, done1;
    logic [2:0] idx1;
    logic [7:0] ft1, qt1;

    exp_t sb5[$];
    exp_t sb1[$];

    // 0: parity/AND, 1: a|b / ~c, 2: reference model of odev1_a
    function automatic logic [1:0] stub(int m, logic [2:0] v);
        case (m)
            0:       return {^v, &v};
            1:       return {v[2] | v[1], ~v[0]};
            default: return {(v[2] & v[1]) | (~v[1] & v[0]), v[2] ^ v[0]};
        endcase
    endfunction

    function automatic exp_t ref_tables(int m);
        exp_t       e;
        logic [1:0] r;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            r = stub(m, 3'(i));
            e.f[i] = r[1];
            e.q[i] = r[0];
        end
        return e;
    endfunction

    function automatic exp_t mk(logic [7:0] ef, logic [7:0] eq);
        exp_t e;
        e.f = ef;
        e.q = eq;
        return e;
    endfunction

    always_comb {f5, q5} = stub(mode5, {a5, b5, c5});
    always_comb {f1, q1} = stub(mode1, {a1, b1, c1});

    odev1_vec_seq #(.HOLD_CYCLES(5), .HOLD_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(s5), .f(f5), .q(q5),
        .a(a5), .b(b5), .c(c5), .vec_idx(idx5), .busy(busy5), .done(done5),
        .f_table(ft5), .q_table(qt5)
    );

    odev1_vec_seq #(.HOLD_CYCLES(1), .HOLD_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .f(f1), .q(q1),
        .a(a1), .b(b1), .c(c1), .vec_idx(idx1), .busy(busy1), .done(done1),
        .f_table(ft1), .q_table(qt1)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic err(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    // Monitors: pop an expectation on every done pulse.
    int   bc5 = 0, bc1 = 0;
    logic [2:0] pidx5 = '0, pidx1 = '0;
    exp_t e5, e1;

    always @(negedge clk) begin
        if (!rst_n) begin
            bc5 = 0;
        end else begin
            if (busy5 && done5) err("busy_and_done_h5");
            if ({a5, b5, c5} !== idx5) err("abc_vs_idx_h5");
            if (busy5) begin
                if (bc5 > 0 && idx5 < pidx5) err("idx_monotonic_h5");
                pidx5 = idx5;
                bc5++;
            end
            if (done5) begin
                chk("busy_len_h5", bc5, 40);
                bc5 = 0;
                if (sb5.size() > 0) begin
                    e5 = sb5.pop_front();
                    chk("f_table_h5", ft5, e5.f);
                    chk("q_table_h5", qt5, e5.q);
                end else begin
                    err("unexpected_done_h5");
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bc1 = 0;
        end else begin
            if (busy1 && done1) err("busy_and_done_h1");
            if ({a1, b1, c1} !== idx1) err("abc_vs_idx_h1");
            if (busy1) begin
                if (bc1 > 0 && idx1 < pidx1) err("idx_monotonic_h1");
                pidx1 = idx1;
                bc1++;
            end
            if (done1) begin
                chk("busy_len_h1", bc1, 8);
                bc1 = 0;
                if (sb1.size() > 0) begin
                    e1 = sb1.pop_front();
                    chk("f_table_h1", ft1, e1.f);
                    chk("q_table_h1", qt1, e1.q);
                end else begin
                    err("unexpected_done_h1");
                end
            end
        end
    end

    task automatic pulse5();
        s5 = 1'b1;
        @(posedge clk);
        #1 s5 = 1'b0;
    endtask

    task automatic pulse1();
        s1 = 1'b1;
        @(posedge clk);
        #1 s1 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb5.size() > 0 || sb1.size() > 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb5.size() > 0 || sb1.size() > 0) begin
            err("drain_timeout");
            sb5.delete();
            sb1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_abc", {a5, b5, c5}, 0);
        chk("rst_idx", idx5, 0);
        chk("rst_ftab", ft5, 0);
        chk("rst_qtab", qt5, 0);
        chk("rst_busy_h1", busy1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // parity/AND at H=5, stepping checked every cycle
        mode5 = 0;
        sb5.push_back(mk(8'h96, 8'h80));
        pulse5();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("step_idx", idx5, k / 5);
        end
        @(negedge clk);
        chk("done_after_40", done5, 1);
        chk("busy_low_in_done", busy5, 0);
        drain();

        // second run with a different function must fully overwrite
        // (a|b is 0 only for idx 0,1; ~c is 1 for even idx)
        mode5 = 1;
        sb5.push_back(mk(8'hFC, 8'h55));
        pulse5();
        drain();

        // reference model of odev1_a
        mode5 = 2;
        sb5.push_back(ref_tables(2));
        pulse5();
        drain();

        // H=1: done in the ninth cycle after start
        mode1 = 1;
        sb1.push_back(mk(8'hFC, 8'h55));
        pulse1();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("h1_busy", busy1, 1);
        end
        @(negedge clk);
        chk("h1_done_cycle9", done1, 1);
        drain();

        // start pulses inside DRIVE and DONE are ignored
        mode5 = 0;
        sb5.push_back(mk(8'h96, 8'h80));
        pulse5();
        repeat (10) @(negedge clk);
        pulse5();
        t = 0;
        while (!done5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done5, 1);
        pulse5();
        repeat (3) @(negedge clk);
        chk("no_restart", busy5, 0);
        drain();

        // start held high: back-to-back runs
        mode5 = 0;
        repeat (3) sb5.push_back(mk(8'h96, 8'h80));
        s5 = 1'b1;
        t = 0;
        while (sb5.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        s5 = 1'b0;
        chk("held_runs_left", sb5.size(), 0);
        repeat (3) @(negedge clk);
        chk("held_stop", busy5, 0);
        drain();

        // reset at vector 4, hold cycle 2
        mode5 = 0;
        sb5.push_back(mk(8'h96, 8'h80));
        pulse5();
        repeat (23) @(negedge clk);
        chk("pre_rst_idx", idx5, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy5, 0);
        chk("mid_rst_abc", {a5, b5, c5}, 0);
        chk("mid_rst_ftab", ft5, 0);
        chk("mid_rst_qtab", qt5, 0);
        sb5.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode5 = 1;
        sb5.push_back(mk(8'hFC, 8'h55));
        pulse5();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
